// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of one PWM line
// in tick_en units and offers {meas_high, meas_period} on a valid/ready port.
// A line with no rising edge for TIMEOUT ticks is flagged as stuck.
module pwm_capture #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_overrun,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             stuck_high
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
  logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
  logic [CNT_W-1:0] hi_lat_reg, hi_lat_next;
  logic             timeout_next, stuck_next;
  logic             emit;

  logic sync1_reg, s_reg, s_prev_reg;
  logic rise, fall;
  logic [CNT_W-1:0] tick_inc;

  assign rise     = s_reg & ~s_prev_reg;
  assign fall     = ~s_reg & s_prev_reg;
  assign tick_inc = {{(CNT_W-1){1'b0}}, tick_en};

  // Two-flop synchronizer for the asynchronous PWM line plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg  <= 1'b0;
      s_reg      <= 1'b0;
      s_prev_reg <= 1'b0;
    end else begin
      sync1_reg  <= pwm_in;
      s_reg      <= sync1_reg;
      s_prev_reg <= s_reg;
    end
  end

  // FSM state and measurement counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      hi_cnt_reg  <= '0;
      per_cnt_reg <= '0;
      hi_lat_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      hi_cnt_reg  <= hi_cnt_next;
      per_cnt_reg <= per_cnt_next;
      hi_lat_reg  <= hi_lat_next;
    end
  end

  // Next-state logic: a rise always starts a new period (and wins over timeout);
  // the rise cycle itself is counted as the first tick of the new period
  always_comb begin
    state_next   = state_reg;
    hi_cnt_next  = hi_cnt_reg;
    per_cnt_next = per_cnt_reg;
    hi_lat_next  = hi_lat_reg;
    timeout_next = timeout;
    stuck_next   = stuck_high;
    emit         = 1'b0;
    if (rise) begin
      emit         = (state_reg == LOW);
      state_next   = HIGH;
      hi_cnt_next  = tick_inc;
      per_cnt_next = tick_inc;
      timeout_next = 1'b0;
      stuck_next   = 1'b0;
    end else if (per_cnt_reg == TIMEOUT_C) begin
      timeout_next = 1'b1;
      stuck_next   = s_reg;
      per_cnt_next = '0;
      hi_cnt_next  = '0;
      state_next   = IDLE;
    end else begin
      case (state_reg)
        HIGH: begin
          per_cnt_next = per_cnt_reg + tick_inc;
          if (fall) begin
            // fall cycle is already low time, so the high count stops here
            hi_lat_next = hi_cnt_reg;
            state_next  = LOW;
          end else begin
            hi_cnt_next = hi_cnt_reg + tick_inc;
          end
        end
        default: per_cnt_next = per_cnt_reg + tick_inc;
      endcase
    end
  end

  // Output register and valid/ready handshake; a new emit always loads fresh data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meas_high    <= '0;
      meas_period  <= '0;
      meas_overrun <= 1'b0;
      meas_valid   <= 1'b0;
      timeout      <= 1'b0;
      stuck_high   <= 1'b0;
    end else begin
      timeout    <= timeout_next;
      stuck_high <= stuck_next;
      if (emit) begin
        meas_high    <= hi_lat_reg;
        meas_period  <= per_cnt_reg;
        meas_overrun <= meas_valid & ~meas_ready;
        meas_valid   <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed-vector bench for pwm_capture with hand-computed
// expected measurements.
module tb_pwm_capture;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick_en;
  logic             pwm_in;
  logic             meas_ready;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_period;
  logic             meas_overrun;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_high;

  int   vec_cnt   = 0;
  int   err_cnt   = 0;
  int   xfer_cnt  = 0;
  int   last_high = 0;
  int   last_per  = 0;
  int   last_ovr  = 0;
  int   tick_ph   = 0;
  int   x0        = 0;
  logic tick_div4 = 1'b0;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(4095)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_en      (tick_en),
    .pwm_in       (pwm_in),
    .meas_high    (meas_high),
    .meas_period  (meas_period),
    .meas_overrun (meas_overrun),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .timeout      (timeout),
    .stuck_high   (stuck_high)
  );

  always #5 clk = ~clk;

  // record every completed transfer, sampled on the falling edge
  always @(negedge clk) begin
    if (rst && meas_valid && meas_ready) begin
      xfer_cnt  = xfer_cnt + 1;
      last_high = int'(meas_high);
      last_per  = int'(meas_period);
      last_ovr  = int'(meas_overrun);
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // advance n clocks; inputs change 1 ns after each rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tick_ph = (tick_ph + 1) % 4;
      tick_en = tick_div4 ? (tick_ph == 0) : 1'b1;
    end
  endtask

  task automatic pwm_cycle(input int hi, input int per);
    pwm_in = 1'b1;
    step(hi);
    pwm_in = 1'b0;
    step(per - hi);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    pwm_in = 1'b0;
    step(2);
    rst = 1'b1;
    step(4);
  endtask

  initial begin
    rst        = 1'b0;
    pwm_in     = 1'b0;
    meas_ready = 1'b1;
    tick_en    = 1'b1;
    #2;
    check_val("rst_valid",   int'(meas_valid),   0);
    check_val("rst_high",    int'(meas_high),    0);
    check_val("rst_period",  int'(meas_period),  0);
    check_val("rst_overrun", int'(meas_overrun), 0);
    check_val("rst_timeout", int'(timeout),      0);
    check_val("rst_stuck",   int'(stuck_high),   0);
    step(3);
    rst = 1'b1;
    step(5);

    // 1: 1500/3000 at full tick rate, latency and single-cycle valid
    x0 = xfer_cnt;
    pwm_cycle(1500, 3000);
    pwm_in = 1'b1;
    step(1);
    step(1);
    check_val("t1_valid_e1", int'(meas_valid), 0);
    step(1);
    check_val("t1_valid_e2", int'(meas_valid),   1);
    check_val("t1_high",     int'(meas_high),    1500);
    check_val("t1_period",   int'(meas_period),  3000);
    check_val("t1_overrun",  int'(meas_overrun), 0);
    step(1);
    check_val("t1_valid_drop", int'(meas_valid), 0);
    step(1496);
    pwm_in = 1'b0;
    step(1500);
    check_val("t1_xfers", xfer_cnt - x0, 1);

    // 2: tick every 4th clock, 400/2000 clk -> 100/500 ticks
    tick_div4 = 1'b1;
    do_reset();
    x0 = xfer_cnt;
    pwm_cycle(400, 2000);
    pwm_cycle(400, 2000);
    pwm_in = 1'b1;
    step(5);
    pwm_in = 1'b0;
    step(2);
    check_val("t2_xfers",  xfer_cnt - x0, 2);
    check_val("t2_high",   last_high, 100);
    check_val("t2_period", last_per,  500);
    tick_div4 = 1'b0;

    // 3: overwrite while not ready, then transfer in the emit cycle
    do_reset();
    meas_ready = 1'b0;
    pwm_cycle(30, 100);
    pwm_cycle(40, 120);
    check_val("t3a_valid",   int'(meas_valid),   1);
    check_val("t3a_high",    int'(meas_high),    30);
    check_val("t3a_period",  int'(meas_period),  100);
    check_val("t3a_overrun", int'(meas_overrun), 0);
    pwm_cycle(50, 90);
    check_val("t3b_valid",   int'(meas_valid),   1);
    check_val("t3b_high",    int'(meas_high),    40);
    check_val("t3b_period",  int'(meas_period),  120);
    check_val("t3b_overrun", int'(meas_overrun), 1);
    pwm_in = 1'b1;
    step(2);
    meas_ready = 1'b1;
    step(1);
    check_val("t3c_valid",   int'(meas_valid),   1);
    check_val("t3c_high",    int'(meas_high),    50);
    check_val("t3c_period",  int'(meas_period),  90);
    check_val("t3c_overrun", int'(meas_overrun), 0);
    step(1);
    check_val("t3c_valid_drop", int'(meas_valid), 0);
    pwm_in = 1'b0;
    step(5);

    // 4: stuck low, then stuck high, then recovery
    do_reset();
    meas_ready = 1'b1;
    x0 = xfer_cnt;
    step(4200);
    check_val("t4_low_timeout", int'(timeout),    1);
    check_val("t4_low_stuck",   int'(stuck_high), 0);
    pwm_in = 1'b1;
    step(4);
    check_val("t4_rise_clears", int'(timeout), 0);
    step(4996);
    check_val("t4_hi_timeout", int'(timeout),    1);
    check_val("t4_hi_stuck",   int'(stuck_high), 1);
    check_val("t4_no_valid",   xfer_cnt - x0,    0);
    pwm_in = 1'b0;
    step(100);
    pwm_cycle(25, 100);
    check_val("t4_clr_timeout", int'(timeout),    0);
    check_val("t4_clr_stuck",   int'(stuck_high), 0);
    pwm_cycle(25, 100);
    check_val("t4_xfers",  xfer_cnt - x0, 1);
    check_val("t4_high",   last_high, 25);
    check_val("t4_period", last_per,  100);

    // 5: 1-clk pulses every 10 clk
    do_reset();
    x0 = xfer_cnt;
    repeat (4) pwm_cycle(1, 10);
    pwm_cycle(1, 10);
    check_val("t5_xfers",  xfer_cnt - x0, 4);
    check_val("t5_high",   last_high, 1);
    check_val("t5_period", last_per,  10);

    // 6: asynchronous reset while HIGH with a pending measurement
    do_reset();
    meas_ready = 1'b0;
    pwm_cycle(20, 50);
    pwm_in = 1'b1;
    step(10);
    check_val("t6_pre_valid", int'(meas_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_rst_valid",  int'(meas_valid),  0);
    check_val("t6_rst_high",   int'(meas_high),   0);
    check_val("t6_rst_period", int'(meas_period), 0);
    pwm_in = 1'b0;
    step(2);
    rst        = 1'b1;
    meas_ready = 1'b1;
    step(5);
    x0 = xfer_cnt;
    pwm_cycle(20, 50);
    check_val("t6_one_rise", xfer_cnt - x0, 0);
    pwm_cycle(20, 50);
    check_val("t6_xfers",  xfer_cnt - x0, 1);
    check_val("t6_high",   last_high, 20);
    check_val("t6_period", last_per,  50);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
